// File: rtl/sps_pkg.sv
// Shared definitions for the parking gate arbiter.
// Holds the arbiter state encoding, the slot count, the mm:ss timer limits,
// and small helpers that derive the occupancy outputs from the slot bitmap.
package sps_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ENTRY_OPEN = 2'd1,
        EXIT_OPEN  = 2'd2
    } state_e;

    localparam int         NUM_SPOTS = 4;
    localparam logic [5:0] SEC_MAX   = 6'd59;
    localparam logic [5:0] MIN_MAX   = 6'd59;

    // Number of free slots in an occupancy bitmap.
    function automatic logic [2:0] free_count(input logic [NUM_SPOTS-1:0] occ);
        logic [2:0] n;
        n = 3'(NUM_SPOTS);
        for (int i = 0; i < NUM_SPOTS; i++) begin
            n = n - {2'b00, occ[i]};
        end
        return n;
    endfunction

    // Index of the lowest free slot; 0 when every slot is taken.
    function automatic logic [1:0] lowest_free(input logic [NUM_SPOTS-1:0] occ);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_SPOTS - 1; i >= 0; i--) begin
            if (!occ[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/slot_timer.sv
// Per-slot parked-time counter in minutes:seconds.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clr_i      : zero the counter (has priority over en_i)
//   en_i       : advance by one second
//   min_o      : minutes, 0..59
//   sec_o      : seconds, 0..59
// The counter stops at 59:59 rather than wrapping.
module slot_timer
    import sps_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr_i,
    input  logic       en_i,
    output logic [5:0] min_o,
    output logic [5:0] sec_o
);

    logic [5:0] min_q, min_d;
    logic [5:0] sec_q, sec_d;
    logic       sat;

    assign sat = (min_q == MIN_MAX) && (sec_q == SEC_MAX);

    always_comb begin
        min_d = min_q;
        sec_d = sec_q;
        if (clr_i) begin
            min_d = '0;
            sec_d = '0;
        end else if (en_i && !sat) begin
            if (sec_q == SEC_MAX) begin
                sec_d = '0;
                min_d = min_q + 6'd1;
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            min_q <= '0;
            sec_q <= '0;
        end else begin
            min_q <= min_d;
            sec_q <= sec_d;
        end
    end

    assign min_o = min_q;
    assign sec_o = sec_q;

endmodule

// File: rtl/gate_arbiter.sv
// Parking gate arbiter: serialises entry and exit requests onto one door.
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   tick_1hz            : one-cycle strobe per second
//   entry_req, exit_req : one-cycle request pulses; exit_slot names the car leaving
//   door_open           : high while an entry or exit is being served
//   is_full, spots, capacity, location : occupancy view derived from the slot bitmap
//   reject              : one-cycle pulse when a request is refused
//   mode                : 1 while an exit is being served (show parked time)
//   minutes, seconds    : parked time of the most recent car to leave
// Requests are latched into pend flags; grants happen only from IDLE and
// alternate between entry and exit when both are waiting.
module gate_arbiter
    import sps_pkg::*;
#(
    parameter int unsigned DOOR_TICKS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic [1:0] exit_slot,
    output logic       door_open,
    output logic       is_full,
    output logic [3:0] spots,
    output logic [2:0] capacity,
    output logic [1:0] location,
    output logic       reject,
    output logic       mode,
    output logic [5:0] minutes,
    output logic [5:0] seconds
);

    localparam logic [3:0] LAST_TICK = 4'(DOOR_TICKS - 1);

    state_e     state_q, state_d;
    logic       entry_pend_q, entry_pend_d;
    logic       exit_pend_q, exit_pend_d;
    logic [1:0] exit_idx_q, exit_idx_d;
    logic       last_exit_q, last_exit_d;   // 1: most recent grant was an exit
    logic [3:0] spots_q, spots_d;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic       reject_q, reject_d;
    logic [5:0] min_q, min_d;
    logic [5:0] sec_q, sec_d;
    logic       grant_entry, grant_exit;

    logic [NUM_SPOTS-1:0] tmr_clr;
    logic [5:0]           tmr_min [NUM_SPOTS];
    logic [5:0]           tmr_sec [NUM_SPOTS];

    for (genvar g = 0; g < NUM_SPOTS; g++) begin : g_tmr
        slot_timer u_tmr (
            .clk   (clk),
            .reset (reset),
            .clr_i (tmr_clr[g]),
            .en_i  (spots_q[g] & tick_1hz),
            .min_o (tmr_min[g]),
            .sec_o (tmr_sec[g])
        );
    end

    assign spots     = spots_q;
    assign capacity  = free_count(spots_q);
    assign location  = lowest_free(spots_q);
    assign is_full   = (spots_q == 4'b1111);
    assign door_open = (state_q != IDLE);
    assign mode      = (state_q == EXIT_OPEN);
    assign reject    = reject_q;
    assign minutes   = min_q;
    assign seconds   = sec_q;

    always_comb begin
        state_d      = state_q;
        entry_pend_d = entry_pend_q;
        exit_pend_d  = exit_pend_q;
        exit_idx_d   = exit_idx_q;
        last_exit_d  = last_exit_q;
        spots_d      = spots_q;
        tick_cnt_d   = tick_cnt_q;
        reject_d     = 1'b0;
        min_d        = min_q;
        sec_d        = sec_q;
        tmr_clr      = '0;
        grant_entry  = 1'b0;
        grant_exit   = 1'b0;

        // A pulse that arrives while its flag is already set is dropped.
        if (entry_req && !entry_pend_q) entry_pend_d = 1'b1;
        if (exit_req && !exit_pend_q) begin
            exit_pend_d = 1'b1;
            exit_idx_d  = exit_slot;
        end

        case (state_q)
            IDLE: begin
                if (entry_pend_q && exit_pend_q) begin
                    grant_entry = last_exit_q;
                    grant_exit  = !last_exit_q;
                end else begin
                    grant_entry = entry_pend_q;
                    grant_exit  = exit_pend_q;
                end

                if (grant_entry) begin
                    entry_pend_d = 1'b0;
                    last_exit_d  = 1'b0;
                    if (is_full) begin
                        reject_d = 1'b1;
                    end else begin
                        spots_d[location] = 1'b1;
                        tmr_clr[location] = 1'b1;
                        tick_cnt_d        = '0;
                        state_d           = ENTRY_OPEN;
                    end
                end else if (grant_exit) begin
                    exit_pend_d = 1'b0;
                    last_exit_d = 1'b1;
                    if (!spots_q[exit_idx_q]) begin
                        reject_d = 1'b1;
                    end else begin
                        spots_d[exit_idx_q] = 1'b0;
                        min_d               = tmr_min[exit_idx_q];
                        sec_d               = tmr_sec[exit_idx_q];
                        tmr_clr[exit_idx_q] = 1'b1;
                        tick_cnt_d          = '0;
                        state_d             = EXIT_OPEN;
                    end
                end
            end
            default: begin
                if (tick_1hz) begin
                    if (tick_cnt_q == LAST_TICK) begin
                        state_d = IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            entry_pend_q <= 1'b0;
            exit_pend_q  <= 1'b0;
            exit_idx_q   <= '0;
            last_exit_q  <= 1'b1;
            spots_q      <= '0;
            tick_cnt_q   <= '0;
            reject_q     <= 1'b0;
            min_q        <= '0;
            sec_q        <= '0;
        end else begin
            state_q      <= state_d;
            entry_pend_q <= entry_pend_d;
            exit_pend_q  <= exit_pend_d;
            exit_idx_q   <= exit_idx_d;
            last_exit_q  <= last_exit_d;
            spots_q      <= spots_d;
            tick_cnt_q   <= tick_cnt_d;
            reject_q     <= reject_d;
            min_q        <= min_d;
            sec_q        <= sec_d;
        end
    end

endmodule
